mem_slave_responder: RTL and testbench
======================================

# mem_slave_responder

Memory-side responder that sits directly downstream of the memory access controller. It decodes the controller's active-low bus strobes (`as_n`, `wr_n`), holds a local register-file memory, inserts a configurable number of wait states, and returns the single-cycle active-low acknowledge (`ack_n`) that closes each transfer. It is the consumer of the controller's bus cycle and the producer of its `ack_n` input.

## Interface
- `ADDR_W`, 6: address width; memory depth is 2^ADDR_W words.
- `DATA_W`, 16: data word width.
- `WAIT_CYCLES`, 2: wait states between request capture and acknowledge; legal range is 0–15.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `as_n`  in  1  address strobe, active low.
- `wr_n`  in  1  0 = write, 1 = read; sampled with `as_n`.
- `addr`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `ack_n`  out  1  transfer acknowledge, active low, one cycle wide.
- `rdata`  out  DATA_W  read data, registered.
- `slv_busy`  out  1  high while state is not IDLE.
- `slv_state`  out  2  current FSM state, for debug.
- `perr`  out  1  read parity error, pulses with `ack_n`.

## Operation
- The FSM has four states, encoded as IDLE=00, WAIT=01, ACK=10, RELEASE=11.
- **IDLE:**
  - If `as_n`=0, capture `addr`, `wr_n` and `wdata` into holding registers.
  - Then go to ACK if WAIT_CYCLES=0; otherwise go to WAIT and load `cnt`=WAIT_CYCLES−1.
  - Bus inputs are sampled only at this capture edge.
- **WAIT:**
  - If `as_n`=1, this is an abort: go to IDLE, with no write and no ack.
  - Else, if `cnt`=0, go to ACK.
  - Else decrement `cnt`.
- **Entering ACK** (same edge as the transition):
  - On a write, `mem[addr_q]` ← `wdata_q`.
  - On a read, `rdata` ← `mem[addr_q]`.
- **ACK:** `ack_n`=0 for exactly this one cycle. At the next edge, go to IDLE if `as_n`=1, else go to RELEASE.
- **RELEASE:** stay until `as_n`=1 is sampled, then go to IDLE. No new request is accepted until IDLE has been re-entered.
- `ack_n`, `slv_busy` and `slv_state` are decoded from registered state only, with no combinational path from the inputs.
- `rdata` holds its value until the next read commits; writes never change it.
- `cnt` is 4 bits wide and never underflows.
- **Reset values:**
  - State is IDLE and `cnt`=0.
  - `ack_n`=1, `rdata`=0, `slv_busy`=0, `slv_state`=00, `perr`=0.
  - Memory contents are not reset.
- **Reset mid-transfer:** return to IDLE with no write committed, unless the ACK-entry edge has already passed.
- **Same-address access:** read-after-write returns the new data, because the write commits before ACK of the write transfer.

## Timing
- Capture edge E0.
- ACK is entered at edge E0+WAIT_CYCLES; `ack_n` is low during the following cycle.
- The controller drops `as_n` on the edge at which it sees `ack_n` low. The responder therefore passes through RELEASE for one cycle and is back in IDLE at E0+WAIT_CYCLES+2.
- Back-to-back throughput: one transfer per WAIT_CYCLES+3 cycles.
- `rdata` and `perr` are valid throughout the `ack_n`-low cycle.

## Configuration
- Macro: `MEM_SLAVE_PARITY_EN`.
- **Defined:**
  - Each word stores an extra even-parity bit, written on commit.
  - On a read commit, the stored parity is compared against recomputed parity, and `perr` is asserted for the ACK cycle on mismatch.
  - Writes never assert `perr`.
- **Undefined:**
  - No parity storage.
  - `perr` is tied to 0; the port remains present.

## Structure
- Shared package `mem_bus_pkg` holds:
  - the state encoding localparams (IDLE, WAIT, ACK, RELEASE);
  - the `ack_n`/`as_n` inactive level constant;
  - the maximum WAIT_CYCLES constant.
- Sub-module `mem_slave_array` is the storage array plus optional parity bit. It has a synchronous write port and a registered read port and is instantiated once.

## Test plan
- **Write, WAIT_CYCLES=2:** `as_n`=0, `wr_n`=0, `addr`=0x05, `wdata`=0xBEEF at E0.
  - Required: `ack_n` low only in the cycle after E0+2; `slv_busy` high from E0 to RELEASE; `rdata` unchanged.
- **Read after write:** read `addr`=0x05.
  - Required: `rdata`=0xBEEF during the `ack_n`-low cycle; `perr`=0.
- **Abort:** `as_n` raised one cycle after E0 of a write of 0x1234 to 0x06.
  - Required: return to IDLE; `ack_n` never low; a later read of 0x06 returns its prior value.
- **Reset in WAIT:** `reset`=1 for one cycle during a write.
  - Required: all outputs at reset values on the next cycle; no write committed.
- **WAIT_CYCLES=0:** read at E0.
  - Required: `ack_n` low in the cycle immediately after E0; three back-to-back reads complete with `ack_n` low every third cycle.
- **`MEM_SLAVE_PARITY_EN`:** write 0x00FF, then flip the stored parity bit via hierarchical deposit, then read.
  - Required: `perr`=1 coincident with `ack_n`=0.
  - Without the macro: `perr` stays 0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared bus constants for the memory controller / responder pair.
// State encoding, strobe inactive level and wait-state limit.
package mem_bus_pkg;

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_WAIT    = 2'b01;
   localparam logic [1:0] ST_ACK     = 2'b10;
   localparam logic [1:0] ST_RELEASE = 2'b11;

   localparam logic BUS_INACTIVE = 1'b1;

   localparam int MAX_WAIT_CYCLES = 15;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_WAIT    = ST_WAIT,
      S_ACK     = ST_ACK,
      S_RELEASE = ST_RELEASE
   } slv_state_t;

endpackage

// File: rtl/mem_slave_array.sv
// Responder storage: sync write port, registered read port.
// MEM_SLAVE_PARITY_EN adds a stored even-parity bit per word.
module mem_slave_array
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              perr
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

`ifdef MEM_SLAVE_PARITY_EN
   logic par_mem [DEPTH];
   logic perr_q;

   always_ff @(posedge clk) begin
      if (we) par_mem[addr] <= ^wdata;
   end

   // Only a read commit may flag; it drops again the following cycle.
   always_ff @(posedge clk) begin
      if (reset) perr_q <= 1'b0;
      else perr_q <= re && (par_mem[addr] != ^mem[addr]);
   end

   assign perr = perr_q;
`else
   assign perr = 1'b0;
`endif

endmodule

// File: rtl/mem_slave_responder.sv
// Memory-side responder: decodes as_n/wr_n, wait states, ack_n pulse.
// Optional read parity checking under MEM_SLAVE_PARITY_EN.
module mem_slave_responder
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              as_n,
   input  logic              wr_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack_n,
   output logic [DATA_W-1:0] rdata,
   output logic              slv_busy,
   output logic [1:0]        slv_state,
   output logic              perr
);

   localparam int WC = (WAIT_CYCLES > MAX_WAIT_CYCLES) ?
                       MAX_WAIT_CYCLES : WAIT_CYCLES;
   localparam logic [3:0] CNT_LOAD = (WC == 0) ? 4'd0 : 4'(WC - 1);

   slv_state_t state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic wr_n_q;
   logic cap, commit;

   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic c_wr_n;
   logic we, re;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (cap) begin
         addr_q  <= addr;
         wdata_q <= wdata;
         wr_n_q  <= wr_n;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cap      = 1'b0;
      commit   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!as_n) begin
               cap = 1'b1;
               if (WC == 0) begin
                  state_nx = S_ACK;
                  commit   = 1'b1;
               end else begin
                  state_nx = S_WAIT;
                  cnt_nx   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (as_n) begin
               state_nx = S_IDLE;
            end else if (cnt == 4'd0) begin
               state_nx = S_ACK;
               commit   = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         S_ACK: begin
            state_nx = as_n ? S_IDLE : S_RELEASE;
         end
         S_RELEASE: begin
            if (as_n) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // With zero wait states the commit edge is also the capture edge,
   // so the live bus must feed the array instead of the holding regs.
   always_comb begin
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_wr_n  = wr_n_q;
      if (state == S_IDLE) begin
         c_addr  = addr;
         c_wdata = wdata;
         c_wr_n  = wr_n;
      end
   end

   assign we = commit && !c_wr_n && !reset;
   assign re = commit &&  c_wr_n && !reset;

   mem_slave_array #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_array (
      .clk  (clk),
      .reset(reset),
      .we   (we),
      .re   (re),
      .addr (c_addr),
      .wdata(c_wdata),
      .rdata(rdata),
      .perr (perr)
   );

   assign ack_n     = (state == S_ACK) ? ~BUS_INACTIVE : BUS_INACTIVE;
   assign slv_busy  = (state != S_IDLE);
   assign slv_state = state;

endmodule

// File: tb/tb_mem_slave_responder.sv
// Directed bench for mem_slave_responder (WAIT_CYCLES=2 and =0).
// Define MEM_SLAVE_PARITY_EN to exercise the parity error path.
module tb_mem_slave_responder;

   logic clk = 1'b0;
   logic reset;

   logic        as_n, wr_n;
   logic [5:0]  addr;
   logic [15:0] wdata;
   logic        ack_n, slv_busy, perr;
   logic [15:0] rdata;
   logic [1:0]  slv_state;

   logic        as0_n, wr0_n;
   logic [5:0]  addr0;
   logic [15:0] wdata0;
   logic        ack0_n, busy0, perr0;
   logic [15:0] rdata0;
   logic [1:0]  state0;

   int tests = 0;
   int fails = 0;

   int          lat;
   logic [15:0] rd;
   logic        pe;

   always #5 clk = ~clk;

   mem_slave_responder #(
      .ADDR_W(6), .DATA_W(16), .WAIT_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset), .as_n(as_n), .wr_n(wr_n),
      .addr(addr), .wdata(wdata), .ack_n(ack_n), .rdata(rdata),
      .slv_busy(slv_busy), .slv_state(slv_state), .perr(perr)
   );

   mem_slave_responder #(
      .ADDR_W(6), .DATA_W(16), .WAIT_CYCLES(0)
   ) dut0 (
      .clk(clk), .reset(reset), .as_n(as0_n), .wr_n(wr0_n),
      .addr(addr0), .wdata(wdata0), .ack_n(ack0_n), .rdata(rdata0),
      .slv_busy(busy0), .slv_state(state0), .perr(perr0)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full controller-side transfer on dut; lat = edges after E0 to ack.
   task automatic xfer(input logic wr, input logic [5:0] a,
                       input logic [15:0] d, output int l,
                       output logic [15:0] r, output logic p);
      as_n  = 1'b0;
      wr_n  = ~wr;
      addr  = a;
      wdata = d;
      tick();
      l = 0;
      while (ack_n !== 1'b0 && l < 20) begin
         tick();
         l++;
      end
      r = rdata;
      p = perr;
      tick();
      as_n = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      as_n = 1'b1; wr_n = 1'b1; addr = '0; wdata = '0;
      as0_n = 1'b1; wr0_n = 1'b1; addr0 = '0; wdata0 = '0;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_ack_n", ack_n, 1'b1);
      chk("rst_rdata", rdata, 16'h0);
      chk("rst_busy", slv_busy, 1'b0);
      chk("rst_state", slv_state, 2'b00);
      chk("rst_perr", perr, 1'b0);

      // Write 0xBEEF to 0x05, cycle by cycle
      as_n = 1'b0; wr_n = 1'b0; addr = 6'h05; wdata = 16'hBEEF;
      tick();
      chk("wr_e0_state", slv_state, 2'b01);
      chk("wr_e0_busy", slv_busy, 1'b1);
      chk("wr_e0_ack", ack_n, 1'b1);
      tick();
      chk("wr_e1_ack", ack_n, 1'b1);
      chk("wr_e1_busy", slv_busy, 1'b1);
      tick();
      chk("wr_e2_ack", ack_n, 1'b0);
      chk("wr_e2_state", slv_state, 2'b10);
      chk("wr_rdata_unch", rdata, 16'h0);
      chk("wr_perr", perr, 1'b0);
      tick();
      chk("wr_rel_state", slv_state, 2'b11);
      chk("wr_rel_ack", ack_n, 1'b1);
      chk("wr_rel_busy", slv_busy, 1'b1);
      as_n = 1'b1;
      tick();
      chk("wr_idle_state", slv_state, 2'b00);
      chk("wr_idle_busy", slv_busy, 1'b0);

      // Read after write
      xfer(1'b0, 6'h05, 16'h0, lat, rd, pe);
      chk("raw_lat", lat, 2);
      chk("raw_rdata", rd, 16'hBEEF);
      chk("raw_perr", pe, 1'b0);

      // Abort: known value at 0x06, then aborted write of 0x1234
      xfer(1'b1, 6'h06, 16'hAAAA, lat, rd, pe);
      chk("pre_abort_lat", lat, 2);
      as_n = 1'b0; wr_n = 1'b0; addr = 6'h06; wdata = 16'h1234;
      tick();
      chk("abort_e0_state", slv_state, 2'b01);
      as_n = 1'b1;
      tick();
      chk("abort_idle", slv_state, 2'b00);
      chk("abort_ack", ack_n, 1'b1);
      tick();
      chk("abort_ack2", ack_n, 1'b1);
      xfer(1'b0, 6'h06, 16'h0, lat, rd, pe);
      chk("abort_rd", rd, 16'hAAAA);

      // Reset during WAIT of a write
      xfer(1'b1, 6'h07, 16'h1111, lat, rd, pe);
      as_n = 1'b0; wr_n = 1'b0; addr = 6'h07; wdata = 16'h2222;
      tick();
      reset = 1'b1;
      as_n  = 1'b1;
      tick();
      reset = 1'b0;
      chk("rwait_ack", ack_n, 1'b1);
      chk("rwait_rdata", rdata, 16'h0);
      chk("rwait_busy", slv_busy, 1'b0);
      chk("rwait_state", slv_state, 2'b00);
      chk("rwait_perr", perr, 1'b0);
      xfer(1'b0, 6'h07, 16'h0, lat, rd, pe);
      chk("rwait_rd", rd, 16'h1111);

      // WAIT_CYCLES=0: write then three back-to-back reads
      as0_n = 1'b0; wr0_n = 1'b0; addr0 = 6'h03; wdata0 = 16'h0C0C;
      tick();
      chk("w0_wr_ack", ack0_n, 1'b0);
      tick();
      as0_n = 1'b1;
      tick();
      wr0_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         as0_n = 1'b0;
         tick();
         chk("w0_rd_ack", ack0_n, 1'b0);
         chk("w0_rd_data", rdata0, 16'h0C0C);
         tick();
         chk("w0_rd_rel", state0, 2'b11);
         chk("w0_rd_ack_hi", ack0_n, 1'b1);
         as0_n = 1'b1;
         tick();
         chk("w0_rd_idle", state0, 2'b00);
      end

      // Parity: corrupt stored parity of 0x09 then read it
      xfer(1'b1, 6'h09, 16'h00FF, lat, rd, pe);
`ifdef MEM_SLAVE_PARITY_EN
      dut.u_array.par_mem[9] = ~dut.u_array.par_mem[9];
`endif
      xfer(1'b0, 6'h09, 16'h0, lat, rd, pe);
      chk("par_lat", lat, 2);
      chk("par_rd", rd, 16'h00FF);
`ifdef MEM_SLAVE_PARITY_EN
      chk("par_perr", pe, 1'b1);
`else
      chk("par_perr", pe, 1'b0);
`endif
      chk("par_perr_clr", perr, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
